// File: rtl/display_pkg.sv
// Shared codes for the 4-digit 7-segment display bus readback.
// Select codes, active-low hex segment table and capture FSM states.
package display_pkg;

    localparam logic [3:0] SEL_DIG0  = 4'b1110;
    localparam logic [3:0] SEL_DIG1  = 4'b1101;
    localparam logic [3:0] SEL_DIG2  = 4'b1011;
    localparam logic [3:0] SEL_DIG3  = 4'b0111;
    localparam logic [3:0] SEL_BLANK = 4'b1111;

    // {g,f,e,d,c,b,a}, segment lit when 0
    localparam logic [6:0] SEG_HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLING,
        ST_CAPTURED
    } state_e;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational decode of an active-low segment pattern to a hex nibble.
// hit_o is low when the pattern is not one of the 16 hex glyphs.
module seg7_to_hex
    import display_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       hit_o,
    output logic [3:0] nibble_o
);

    // Table search; glyphs are unique so at most one entry matches
    always_comb begin
        hit_o    = 1'b0;
        nibble_o = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (seg_i == SEG_HEX[i]) begin
                hit_o    = 1'b1;
                nibble_o = 4'(i);
            end
        end
    end

endmodule

// File: rtl/display_scan_capture.sv
// Display bus monitor: waits for each digit to settle, decodes it and
// publishes a full 4-digit frame once every digit has been captured.
module display_scan_capture
    import display_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 1000,
    parameter int TIMEOUT_CYCLES = 400000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Sw0,
    input  logic        Sw1,
    input  logic        Sw2,
    input  logic        Sw3,
    input  logic [6:0]  Seg,
    output logic [15:0] Frame,
    output logic        FrameValid,
    output logic        SegError,
    output logic        SelError,
    output logic        Stale
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [3:0]      sel;
    logic            sel_valid;
    logic            sel_invalid;
    logic [1:0]      idx;
    logic            change;
    logic            sample;
    logic            hit;
    logic [3:0]      nibble;

    state_e          state_q, state_d;
    logic [SW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   to_q, to_d;
    logic [3:0]      sel_q;
    logic [6:0]      seg_q;
    logic [3:0][3:0] shadow_q, shadow_d;
    logic [3:0]      seen_q, seen_d;
    logic [15:0]     frame_q, frame_d;
    logic            fv_q, fv_d;
    logic            segerr_q, segerr_d;
    logic            selerr_q, selerr_d;

    assign sel    = {Sw3, Sw2, Sw1, Sw0};
    assign change = (sel != sel_q) || (Seg != seg_q);

    seg7_to_hex u_dec (
        .seg_i    (Seg),
        .hit_o    (hit),
        .nibble_o (nibble)
    );

    // Classify the select vector and pick the driven digit
    always_comb begin
        sel_valid   = 1'b1;
        sel_invalid = 1'b0;
        idx         = 2'd0;
        case (sel)
            SEL_DIG0:  idx = 2'd0;
            SEL_DIG1:  idx = 2'd1;
            SEL_DIG2:  idx = 2'd2;
            SEL_DIG3:  idx = 2'd3;
            SEL_BLANK: sel_valid = 1'b0;
            default: begin
                sel_valid   = 1'b0;
                sel_invalid = 1'b1;
            end
        endcase
    end

    // Settle FSM: restart on any bus change, sample once when stable
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sample  = 1'b0;
        if (!sel_valid) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (state_q == ST_IDLE || change) begin
            state_d = ST_SETTLING;
            cnt_d   = '0;
        end else if (state_q == ST_SETTLING) begin
            if (cnt_q == SW'(SETTLE_CYCLES - 1)) begin
                sample  = 1'b1;
                state_d = ST_CAPTURED;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Shadow/seen bookkeeping, frame publication, pulses and timeout
    always_comb begin
        shadow_d = shadow_q;
        seen_d   = seen_q;
        frame_d  = frame_q;
        fv_d     = 1'b0;
        segerr_d = 1'b0;
        selerr_d = sel_invalid && (sel != sel_q);
        if (sample) begin
            if (hit) begin
                shadow_d[idx] = nibble;
                seen_d[idx]   = 1'b1;
                if (&seen_d) begin
                    frame_d = shadow_d;
                    fv_d    = 1'b1;
                    seen_d  = 4'b0000;
                end
            end else begin
                segerr_d = 1'b1;
            end
        end
        if (fv_d) begin
            to_d = '0;
        end else if (to_q == TW'(TIMEOUT_CYCLES)) begin
            to_d = to_q;
        end else begin
            to_d = to_q + 1'b1;
        end
    end

    // State registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            to_q     <= '0;
            sel_q    <= SEL_BLANK;
            seg_q    <= 7'h7F;
            shadow_q <= '0;
            seen_q   <= 4'b0000;
            frame_q  <= 16'h0000;
            fv_q     <= 1'b0;
            segerr_q <= 1'b0;
            selerr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            to_q     <= to_d;
            sel_q    <= sel;
            seg_q    <= Seg;
            shadow_q <= shadow_d;
            seen_q   <= seen_d;
            frame_q  <= frame_d;
            fv_q     <= fv_d;
            segerr_q <= segerr_d;
            selerr_q <= selerr_d;
        end
    end

    assign Frame      = frame_q;
    assign FrameValid = fv_q;
    assign SegError   = segerr_q;
    assign SelError   = selerr_q;
    assign Stale      = (to_q == TW'(TIMEOUT_CYCLES));

endmodule

// File: tb/tb_display_scan_capture.sv
// Bench for display_scan_capture: directed bus scenarios checked every
// cycle against a run-length model, plus literal frame/pulse expectations.
module tb_display_scan_capture;

    localparam int ST = 4;
    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  sel = 4'hF;
    logic [6:0]  seg = 7'h7F;
    logic [15:0] Frame;
    logic        FrameValid, SegError, SelError, Stale;

    int checks = 0;
    int errors = 0;
    int fv_cnt = 0;
    int se_cnt = 0;
    int sle_cnt = 0;
    logic chk_en = 1'b0;

    logic [6:0] hex_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    always #5 clk = ~clk;

    display_scan_capture #(
        .SETTLE_CYCLES  (ST),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .Clock      (clk),
        .Reset      (rst),
        .Sw0        (sel[0]),
        .Sw1        (sel[1]),
        .Sw2        (sel[2]),
        .Sw3        (sel[3]),
        .Seg        (seg),
        .Frame      (Frame),
        .FrameValid (FrameValid),
        .SegError   (SegError),
        .SelError   (SelError),
        .Stale      (Stale)
    );

    // Model: a digit is sampled on the edge where the same (sel,seg)
    // pair has been seen for ST+1 consecutive edges.
    int         run;
    logic [3:0] psel;
    logic [6:0] pseg;
    logic [3:0] m_sh [4];
    logic [3:0] m_seen;
    logic [15:0] m_frame;
    logic       m_fv, m_se, m_sle;
    int         since;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            run = 0; psel = 4'hF; pseg = 7'h7F;
            for (int i = 0; i < 4; i++) m_sh[i] = 4'h0;
            m_seen = 4'h0; m_frame = 16'h0;
            m_fv = 0; m_se = 0; m_sle = 0; since = 0;
        end else begin
            int  d;
            int  hv;
            int  zeros;
            logic done;
            m_fv = 0; m_se = 0; m_sle = 0; done = 0;
            zeros = 0; d = -1;
            for (int i = 0; i < 4; i++)
                if (!sel[i]) begin zeros++; d = i; end
            if (sel != psel || seg != pseg) run = 1;
            else run++;
            m_sle = (zeros > 1) && (sel != psel);
            if (zeros == 1 && run == ST + 1) begin
                hv = -1;
                for (int k = 0; k < 16; k++)
                    if (hex_tab[k] == seg) hv = k;
                if (hv < 0) m_se = 1;
                else begin
                    m_sh[d] = 4'(hv);
                    m_seen[d] = 1'b1;
                    if (m_seen == 4'hF) begin
                        m_frame = {m_sh[3], m_sh[2], m_sh[1], m_sh[0]};
                        m_fv = 1; m_seen = 4'h0; done = 1;
                    end
                end
            end
            if (done) since = 0;
            else if (since < TO) since++;
            psel = sel; pseg = seg;
        end
    end

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Per-cycle compare against the model, plus pulse counters
    always @(negedge clk) begin
        if (chk_en) begin
            check("Frame", Frame, m_frame);
            check("FrameValid", 16'(FrameValid), 16'(m_fv));
            check("SegError", 16'(SegError), 16'(m_se));
            check("SelError", 16'(SelError), 16'(m_sle));
            check("Stale", 16'(Stale), 16'(since == TO));
        end
        if (FrameValid === 1'b1) fv_cnt++;
        if (SegError === 1'b1) se_cnt++;
        if (SelError === 1'b1) sle_cnt++;
    end

    task automatic drive(input logic [3:0] s, input logic [6:0] g,
                         input int n);
        sel = s;
        seg = g;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset Frame", Frame, 16'h0000);
        check("reset Stale", 16'(Stale), 16'h0);
        check("reset FrameValid", 16'(FrameValid), 16'h0);

        drive(4'b1110, hex_tab[1], 10);
        drive(4'b1101, hex_tab[2], 10);
        drive(4'b1011, hex_tab[3], 10);
        drive(4'b0111, hex_tab[4], 10);
        drive(4'hF, 7'h7F, 2);
        check("frame 4321", Frame, 16'h4321);
        check("model frame 4321", m_frame, 16'h4321);
        check("fv count 1", 16'(fv_cnt), 16'd1);
        check("no seg err", 16'(se_cnt), 16'd0);
        check("no sel err", 16'(sle_cnt), 16'd0);

        for (int k = 0; k < 4; k++) drive(4'b1110, hex_tab[k], 3);
        check("model seen after jitter", 16'(m_seen), 16'h0);
        drive(4'b1110, 7'b0000000, 6);
        check("model seen dig0", 16'(m_seen), 16'h1);
        check("model shadow0", 16'(m_sh[0]), 16'h8);
        drive(4'hF, 7'h7F, 2);

        drive(4'b1011, 7'b1111111, 10);
        drive(4'hF, 7'h7F, 2);
        check("seg err count", 16'(se_cnt), 16'd1);
        check("model seen no dig2", 16'(m_seen), 16'h1);

        drive(4'b1100, hex_tab[0], 5);
        check("sel err count", 16'(sle_cnt), 16'd1);
        drive(4'hF, 7'h7F, 2);
        check("sel err held once", 16'(sle_cnt), 16'd1);
        check("model no capture on bad sel", 16'(m_seen), 16'h1);

        drive(4'hF, 7'h7F, 70);
        check("stale set", 16'(Stale), 16'h1);
        drive(4'b1101, hex_tab[5], 10);
        drive(4'b1011, hex_tab[6], 10);
        drive(4'b0111, hex_tab[7], 10);
        drive(4'hF, 7'h7F, 2);
        check("stale cleared", 16'(Stale), 16'h0);
        check("frame 7658", Frame, 16'h7658);
        check("fv count 2", 16'(fv_cnt), 16'd2);

        drive(4'b1110, hex_tab[9], 10);
        drive(4'b1101, hex_tab[10], 10);
        drive(4'b1011, hex_tab[11], 10);
        drive(4'hF, 7'h7F, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid reset Frame", Frame, 16'h0000);
        check("mid reset FrameValid", 16'(FrameValid), 16'h0);
        check("model seen cleared", 16'(m_seen), 16'h0);
        @(negedge clk);
        rst = 1'b0;
        check("no frame from partial", 16'(fv_cnt), 16'd2);
        drive(4'b1110, hex_tab[12], 10);
        drive(4'b1101, hex_tab[13], 10);
        drive(4'b1011, hex_tab[14], 10);
        drive(4'b0111, hex_tab[15], 10);
        drive(4'hF, 7'h7F, 2);
        check("frame FEDC", Frame, 16'hFEDC);
        check("fv count 3", 16'(fv_cnt), 16'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks,
                 errors);
        $finish;
    end

endmodule
